pipe_ctrl: RTL

Pipeline controller for the five-stage OpenMIPS core. It merges stall requests from the IF bus, ID, EX and MEM into the 6-bit stall vector consumed by pc_reg and the stage registers. It turns MEM-stage exceptions into a one-cycle flush plus a redirect address (new_pc), then masks further exceptions during a programmable recovery window. It also keeps an exception counter and a stall watchdog for debug.

---
 rtl/pipe_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline controller: merges stage stall requests, converts MEM-stage exceptions
// into a one-cycle flush with redirect, masks exceptions while recovering, and tracks debug counters.
module pipe_ctrl #(
    parameter logic [31:0] EXC_VECTOR     = 32'h00000020,
    parameter int unsigned RECOVER_CYCLES = 2,
    parameter int unsigned WDOG_LIMIT     = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_from_if,
    input  logic        stallreq_from_id,
    input  logic        stallreq_from_ex,
    input  logic        stallreq_from_mem,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] cp0_epc_i,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        recovering,
    output logic [15:0] exc_count,
    output logic        wdog_timeout
);

    localparam int unsigned     WD_W      = $clog2(WDOG_LIMIT) + 1;
    localparam logic [WD_W-1:0] WD_MAX    = WD_W'(WDOG_LIMIT - 1);
    localparam logic [3:0]      RC_INIT   = 4'(RECOVER_CYCLES - 1);
    localparam logic [31:0]     ERET_CODE = 32'h0000000e;

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_RECOVER = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        rcnt_q, rcnt_d;
    logic [15:0]       exc_count_q, exc_count_d;
    logic [WD_W-1:0]   stall_run_q, stall_run_d;
    logic              wdog_q, wdog_d;

    logic              exc_take_s;
    logic [5:0]        stall_s;
    logic [31:0]       new_pc_s;

    // Exception acceptance and redirect target
    always_comb begin
        exc_take_s = (state_q == ST_RUN) && (excepttype_i != 32'h00000000) && !rst;
        if (!exc_take_s) begin
            new_pc_s = 32'h00000000;
        end else if (excepttype_i == ERET_CODE) begin
            new_pc_s = cp0_epc_i;
        end else begin
            new_pc_s = EXC_VECTOR;
        end
    end

    // Stall vector: a flush overrides every request; deeper stages win otherwise
    always_comb begin
        if (rst || exc_take_s) begin
            stall_s = 6'b000000;
        end else if (stallreq_from_mem) begin
            stall_s = 6'b011111;
        end else if (stallreq_from_ex) begin
            stall_s = 6'b001111;
        end else if (stallreq_from_id) begin
            stall_s = 6'b000111;
        end else if (stallreq_from_if) begin
            stall_s = 6'b000111;
        end else begin
            stall_s = 6'b000000;
        end
    end

    // Next-state for the recovery FSM and the debug counters
    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        case (state_q)
            ST_RUN: begin
                if (exc_take_s) begin
                    state_d = ST_RECOVER;
                    rcnt_d  = RC_INIT;
                end else begin
                    state_d = ST_RUN;
                    rcnt_d  = rcnt_q;
                end
            end
            ST_RECOVER: begin
                // rcnt==0 marks the last masked cycle
                if (rcnt_q == 4'd0) begin
                    state_d = ST_RUN;
                end else begin
                    rcnt_d = rcnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_RUN;
                rcnt_d  = 4'd0;
            end
        endcase

        if (exc_take_s && (exc_count_q != 16'hFFFF)) begin
            exc_count_d = exc_count_q + 16'd1;
        end else begin
            exc_count_d = exc_count_q;
        end

        if (!stall_s[0]) begin
            stall_run_d = '0;
        end else if (stall_run_q != WD_MAX) begin
            stall_run_d = stall_run_q + WD_W'(1);
        end else begin
            stall_run_d = stall_run_q;
        end

        wdog_d = wdog_q | (stall_s[0] && (stall_run_q == WD_MAX));
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            rcnt_q      <= 4'd0;
            exc_count_q <= 16'd0;
            stall_run_q <= '0;
            wdog_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rcnt_q      <= rcnt_d;
            exc_count_q <= exc_count_d;
            stall_run_q <= stall_run_d;
            wdog_q      <= wdog_d;
        end
    end

    // Outputs are forced low for as long as reset is held
    assign stall        = stall_s;
    assign flush        = exc_take_s;
    assign new_pc       = new_pc_s;
    assign recovering   = (state_q == ST_RECOVER) && !rst;
    assign exc_count    = rst ? 16'd0 : exc_count_q;
    assign wdog_timeout = wdog_q && !rst;

endmodule
